// File: rtl/game_ctrl.sv
// Per-frame game controller: bird physics, pipe recycling, collision latch and score,
// all advanced once per new_frame pulse and presented as registered sprite positions.
module game_ctrl #(
    parameter int BIRD_X   = 200,
    parameter int START_Y  = 240,
    parameter int GROUND_Y = 400,
    parameter int GRAVITY  = 2,
    parameter int FLAP_V   = 56,
    parameter int VMAX     = 96,
    parameter int SPEED    = 2,
    parameter int PIPE_W   = 52,
    parameter int SPACING  = 240,
    parameter int Y_BASE   = -50
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               button_press,
    input  logic               new_frame,
    input  logic               hit,
    output logic [1:0]         game_state,
    output logic [7:0]         stage_shift,
    output logic signed [15:0] pipe1_pos_x,
    output logic signed [15:0] pipe2_pos_x,
    output logic signed [15:0] pipe3_pos_x,
    output logic signed [15:0] pipe1_pos_y,
    output logic signed [15:0] pipe2_pos_y,
    output logic signed [15:0] pipe3_pos_y,
    output logic signed [15:0] bird_pos_x,
    output logic signed [15:0] bird_pos_y,
    output logic signed [7:0]  bird_angle,
    output logic [1:0]         bird_status,
    output logic [15:0]        score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic signed [15:0] VY_FLAP   = 16'(-FLAP_V);
    localparam logic signed [15:0] GRAV16    = 16'(GRAVITY);
    localparam logic signed [15:0] VMAX16    = 16'(VMAX);
    localparam logic signed [15:0] SPD16     = 16'(SPEED);
    localparam logic [7:0]         SPD8      = 8'(SPEED);
    localparam logic signed [15:0] PW16      = 16'(PIPE_W);
    localparam logic signed [15:0] WRAP_LIM  = 16'(-PIPE_W);
    localparam logic signed [15:0] SPAN16    = 16'(3 * SPACING);
    localparam logic signed [15:0] BX16      = 16'(BIRD_X);
    localparam logic signed [15:0] GROUND16  = 16'(GROUND_Y);
    localparam logic signed [15:0] YBASE16   = 16'(Y_BASE);
    localparam logic signed [19:0] START_FP  = 20'(START_Y * 16);
    localparam logic signed [19:0] GROUND_FP = 20'(GROUND_Y * 16);
    localparam logic signed [15:0] ANG_LO    = -16'sd20;
    localparam logic signed [15:0] ANG_HI    = 16'sd90;
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;

    state_t              state, state_n;
    logic signed [19:0]  pos_fp, pos_n;
    logic signed [15:0]  vy, vy_n;
    logic signed [15:0]  pipe_x [3];
    logic signed [15:0]  pipe_y [3];
    logic signed [15:0]  px_n [3];
    logic signed [15:0]  py_n [3];
    logic [7:0]          stage_r, stage_n;
    logic [15:0]         score_r, score_n;
    logic [1:0]          status_r, status_n;
    logic [2:0]          fcnt, fcnt_n;
    logic signed [7:0]   angle_r, angle_n;
    logic [15:0]         lfsr;
    logic                flap_pend, hit_lat;

    logic                flap_v, hit_v;
    logic signed [15:0]  vy_grav, vy_t, nx, va;
    logic signed [19:0]  pos_t;
    logic [1:0]          crossings;
    logic [17:0]         sc_sum;

    // Pulses coincident with new_frame are folded into that frame's update.
    assign flap_v = flap_pend | button_press;
    assign hit_v  = hit_lat | (hit && state == PLAY);

    always_comb begin
        state_n   = state;
        pos_n     = pos_fp;
        vy_n      = vy;
        px_n      = pipe_x;
        py_n      = pipe_y;
        stage_n   = stage_r;
        score_n   = score_r;
        status_n  = status_r;
        fcnt_n    = fcnt;
        angle_n   = angle_r;
        vy_t      = '0;
        pos_t     = '0;
        nx        = '0;
        va        = '0;
        crossings = '0;
        sc_sum    = '0;

        vy_grav = vy + GRAV16;
        if (vy_grav > VMAX16) begin
            vy_grav = VMAX16;
        end

        if (new_frame) begin
            case (state)
                IDLE: begin
                    stage_n = stage_r + SPD8;
                    pos_n   = START_FP;
                    if (flap_v) begin
                        state_n = PLAY;
                        vy_n    = VY_FLAP;
                    end
                end
                PLAY: begin
                    vy_t  = flap_v ? VY_FLAP : vy_grav;
                    pos_t = pos_fp + {{4{vy_t[15]}}, vy_t};
                    if (pos_t[19]) begin
                        pos_t = '0;
                        vy_t  = '0;
                    end
                    vy_n  = vy_t;
                    pos_n = pos_t;
                    for (int unsigned i = 0; i < 3; i++) begin
                        nx = pipe_x[i] - SPD16;
                        if (nx < WRAP_LIM) begin
                            nx      = nx + SPAN16;
                            py_n[i] = YBASE16 + $signed({8'h00, lfsr[7:0]});
                        end
                        px_n[i] = nx;
                        if ((pipe_x[i] + PW16 >= BX16) && (nx + PW16 < BX16)) begin
                            crossings = crossings + 2'd1;
                        end
                    end
                    sc_sum  = {2'b00, score_r} + {16'd0, crossings};
                    score_n = (sc_sum[17:16] != 2'b00) ? '1 : sc_sum[15:0];
                    stage_n = stage_r + SPD8;
                    if (hit_v || ($signed(pos_t[19:4]) >= GROUND16)) begin
                        state_n = DYING;
                    end
                end
                DYING: begin
                    pos_t = pos_fp + {{4{vy_grav[15]}}, vy_grav};
                    if ($signed(pos_t[19:4]) >= GROUND16) begin
                        pos_n   = GROUND_FP;
                        vy_n    = '0;
                        state_n = OVER;
                    end else begin
                        pos_n = pos_t;
                        vy_n  = vy_grav;
                    end
                end
                OVER: begin
                    if (flap_v) begin
                        state_n  = IDLE;
                        pos_n    = START_FP;
                        vy_n     = '0;
                        px_n[0]  = 16'sd640;
                        px_n[1]  = 16'sd880;
                        px_n[2]  = 16'sd1120;
                        py_n[0]  = 16'sd0;
                        py_n[1]  = 16'sd100;
                        py_n[2]  = 16'sd200;
                        stage_n  = '0;
                        score_n  = '0;
                        status_n = '0;
                        fcnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase

            if (state == IDLE || state == PLAY) begin
                fcnt_n = fcnt + 3'd1;
                if (fcnt == 3'd7) begin
                    status_n = status_r + 2'd1;
                end
            end

            va = vy_n >>> 2;
            if (va < ANG_LO) begin
                va = ANG_LO;
            end else if (va > ANG_HI) begin
                va = ANG_HI;
            end
            angle_n = (state_n == IDLE) ? 8'sd0 : va[7:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pos_fp    <= START_FP;
            vy        <= '0;
            pipe_x[0] <= 16'sd640;
            pipe_x[1] <= 16'sd880;
            pipe_x[2] <= 16'sd1120;
            pipe_y[0] <= 16'sd0;
            pipe_y[1] <= 16'sd100;
            pipe_y[2] <= 16'sd200;
            stage_r   <= '0;
            score_r   <= '0;
            status_r  <= '0;
            fcnt      <= '0;
            angle_r   <= '0;
        end else begin
            state    <= state_n;
            pos_fp   <= pos_n;
            vy       <= vy_n;
            pipe_x   <= px_n;
            pipe_y   <= py_n;
            stage_r  <= stage_n;
            score_r  <= score_n;
            status_r <= status_n;
            fcnt     <= fcnt_n;
            angle_r  <= angle_n;
        end
    end

    // LFSR and event latches run every cycle, independent of the frame update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr      <= LFSR_SEED;
            flap_pend <= 1'b0;
            hit_lat   <= 1'b0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (new_frame) begin
                flap_pend <= 1'b0;
                hit_lat   <= 1'b0;
            end else begin
                if (button_press) begin
                    flap_pend <= 1'b1;
                end
                if (hit && state == PLAY) begin
                    hit_lat <= 1'b1;
                end
            end
        end
    end

    assign game_state  = state;
    assign stage_shift = stage_r;
    assign pipe1_pos_x = pipe_x[0];
    assign pipe2_pos_x = pipe_x[1];
    assign pipe3_pos_x = pipe_x[2];
    assign pipe1_pos_y = pipe_y[0];
    assign pipe2_pos_y = pipe_y[1];
    assign pipe3_pos_y = pipe_y[2];
    assign bird_pos_x  = BX16;
    assign bird_pos_y  = pos_fp[19:4];
    assign bird_angle  = angle_r;
    assign bird_status = status_r;
    assign score       = score_r;

endmodule
